// File: rtl/pin_lock_pkg.sv
// Shared types and constants for the 4-digit PIN lock controller.
// PIN_LOCK_PROGRAM_EN adds the PROG state for PIN reprogramming.
package pin_lock_pkg;

  localparam int PIN_DIGITS = 4;

  typedef logic [3:0] bcd_t;
  typedef bcd_t [PIN_DIGITS-1:0] pin_t;

  // Element k holds pin[k], so the literal reads pin[3]..pin[0]: PIN 9,9,7,9.
  localparam pin_t PIN_DEFAULT = {4'd9, 4'd7, 4'd9, 4'd9};

`ifdef PIN_LOCK_PROGRAM_EN
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_LOCKOUT  = 3'd3,
    ST_PROG     = 3'd4
  } pin_lock_state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ENTRY    = 3'd1,
    ST_UNLOCKED = 3'd2,
    ST_LOCKOUT  = 3'd3
  } pin_lock_state_t;
`endif

  // Non-BCD codes never match, even if one was programmed into the PIN.
  function automatic logic digit_bad(input bcd_t d, input bcd_t p);
    return (d > 4'd9) || (d != p);
  endfunction

endpackage

// File: rtl/pin_lock_ctrl_if.sv
// Keypad-side and status-side signals of the PIN lock controller.
// PIN_LOCK_PROGRAM_EN adds the prog strobe.
interface pin_lock_ctrl_if;
  import pin_lock_pkg::*;

  // enter/cancel/prog are single-cycle strobes, each high for exactly one
  // clk cycle per event; digit is valid only in a cycle where enter is high.
  // There is no ready: the controller consumes or deliberately ignores every
  // strobe in the cycle it is presented.
  bcd_t       digit;
  logic       enter;
  logic       cancel;
`ifdef PIN_LOCK_PROGRAM_EN
  logic       prog;
`endif
  logic [1:0] digit_idx;
  logic       unlock;
  logic       error;
  logic       locked_out;
  logic [2:0] fail_cnt;

`ifdef PIN_LOCK_PROGRAM_EN
  modport master (output digit, enter, cancel, prog,
                  input  digit_idx, unlock, error, locked_out, fail_cnt);
  modport slave  (input  digit, enter, cancel, prog,
                  output digit_idx, unlock, error, locked_out, fail_cnt);
`else
  modport master (output digit, enter, cancel,
                  input  digit_idx, unlock, error, locked_out, fail_cnt);
  modport slave  (input  digit, enter, cancel,
                  output digit_idx, unlock, error, locked_out, fail_cnt);
`endif

endinterface

// File: rtl/pin_lock_timer.sv
// Loadable down-counter shared by the unlock hold and the lockout window.
// Stops at zero instead of wrapping.
module pin_lock_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_value,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_value;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_zero = (r_count == '0);

endmodule

// File: rtl/pin_lock_ctrl.sv
// PIN lock sequencer: 4-digit compare, failure counting, timed unlock/lockout.
// PIN_LOCK_PROGRAM_EN adds PIN reprogramming from the UNLOCKED state.
module pin_lock_ctrl
  import pin_lock_pkg::*;
#(
  parameter int UNLOCK_CYCLES  = 1000,
  parameter int LOCKOUT_CYCLES = 5000,
  parameter int MAX_FAILS      = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  pin_lock_ctrl_if.slave  bus,
  output pin_lock_state_t o_dbg_state
);

  localparam int MAX_CYC = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0] UNLOCK_LOAD  = TW'(UNLOCK_CYCLES - 1);
  localparam logic [TW-1:0] LOCKOUT_LOAD = TW'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]    MAX_F        = 3'(MAX_FAILS);

  pin_lock_state_t r_state, w_state;
  logic [1:0]      r_idx, w_idx;
  logic            r_mismatch, w_mismatch;
  logic [2:0]      r_fail_cnt, w_fail_cnt;
  logic            r_unlock, w_unlock;
  logic            r_error, w_error;
  logic            r_locked_out, w_locked_out;

  logic            w_tmr_load;
  logic [TW-1:0]   w_tmr_value;
  logic            w_tmr_zero;
  logic [2:0]      w_fail_inc;
  logic            w_digit_bad;
  pin_t            w_pin;

`ifdef PIN_LOCK_PROGRAM_EN
  pin_t r_pin;
  pin_t r_shadow;

  // Writes land in the shadow; the live PIN changes only on the 4th digit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pin    <= PIN_DEFAULT;
      r_shadow <= PIN_DEFAULT;
    end else if (r_state == ST_PROG && bus.enter && !bus.cancel) begin
      r_shadow[r_idx] <= bus.digit;
      if (r_idx == 2'd3) begin
        r_pin <= {bus.digit, r_shadow[2], r_shadow[1], r_shadow[0]};
      end
    end
  end

  assign w_pin = r_pin;
`else
  assign w_pin = PIN_DEFAULT;
`endif

  // In IDLE r_idx is always 0, so one indexed compare serves both states.
  assign w_digit_bad = digit_bad(bus.digit, w_pin[r_idx]);
  assign w_fail_inc  = (r_fail_cnt < MAX_F) ? r_fail_cnt + 3'd1 : MAX_F;

  pin_lock_timer #(.W(TW)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_load  (w_tmr_load),
    .i_value (w_tmr_value),
    .o_zero  (w_tmr_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_idx        <= 2'd0;
      r_mismatch   <= 1'b0;
      r_fail_cnt   <= 3'd0;
      r_unlock     <= 1'b0;
      r_error      <= 1'b0;
      r_locked_out <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_idx        <= w_idx;
      r_mismatch   <= w_mismatch;
      r_fail_cnt   <= w_fail_cnt;
      r_unlock     <= w_unlock;
      r_error      <= w_error;
      r_locked_out <= w_locked_out;
    end
  end

  always_comb begin
    w_state      = r_state;
    w_idx        = r_idx;
    w_mismatch   = r_mismatch;
    w_fail_cnt   = r_fail_cnt;
    w_unlock     = r_unlock;
    w_error      = 1'b0;
    w_locked_out = r_locked_out;
    w_tmr_load   = 1'b0;
    w_tmr_value  = '0;

    case (r_state)
      ST_IDLE: begin
        if (bus.enter && !bus.cancel) begin
          w_mismatch = w_digit_bad;
          w_idx      = 2'd1;
          w_state    = ST_ENTRY;
        end
      end

      ST_ENTRY: begin
        if (bus.cancel) begin
          w_state    = ST_IDLE;
          w_idx      = 2'd0;
          w_mismatch = 1'b0;
        end else if (bus.enter) begin
          if (r_idx != 2'd3) begin
            w_idx      = r_idx + 2'd1;
            w_mismatch = r_mismatch | w_digit_bad;
          end else begin
            // Verdict only after the 4th digit so an early miss is not revealed.
            w_idx      = 2'd0;
            w_mismatch = 1'b0;
            if (!(r_mismatch | w_digit_bad)) begin
              w_state     = ST_UNLOCKED;
              w_fail_cnt  = 3'd0;
              w_unlock    = 1'b1;
              w_tmr_load  = 1'b1;
              w_tmr_value = UNLOCK_LOAD;
            end else begin
              w_fail_cnt = w_fail_inc;
              w_error    = 1'b1;
              if (w_fail_inc == MAX_F) begin
                w_state      = ST_LOCKOUT;
                w_locked_out = 1'b1;
                w_tmr_load   = 1'b1;
                w_tmr_value  = LOCKOUT_LOAD;
              end else begin
                w_state = ST_IDLE;
              end
            end
          end
        end
      end

      ST_UNLOCKED: begin
        if (bus.cancel || w_tmr_zero) begin
          w_state  = ST_IDLE;
          w_unlock = 1'b0;
        end
`ifdef PIN_LOCK_PROGRAM_EN
        else if (bus.prog) begin
          w_state = ST_PROG;
          w_idx   = 2'd0;
        end
`endif
      end

      ST_LOCKOUT: begin
        if (w_tmr_zero) begin
          w_state      = ST_IDLE;
          w_locked_out = 1'b0;
          w_fail_cnt   = 3'd0;
        end
      end

`ifdef PIN_LOCK_PROGRAM_EN
      ST_PROG: begin
        if (bus.cancel) begin
          w_state  = ST_IDLE;
          w_idx    = 2'd0;
          w_unlock = 1'b0;
        end else if (bus.enter) begin
          if (r_idx == 2'd3) begin
            w_state  = ST_IDLE;
            w_idx    = 2'd0;
            w_unlock = 1'b0;
          end else begin
            w_idx = r_idx + 2'd1;
          end
        end
      end
`endif

      default: w_state = ST_IDLE;
    endcase
  end

  assign bus.digit_idx  = r_idx;
  assign bus.unlock     = r_unlock;
  assign bus.error      = r_error;
  assign bus.locked_out = r_locked_out;
  assign bus.fail_cnt   = r_fail_cnt;
  assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_pin_lock_ctrl.sv
// Self-checking bench for pin_lock_ctrl: transaction model feeds an expected
// queue; a monitor compares the registered response after every strobe.
module tb_pin_lock_ctrl;
  import pin_lock_pkg::*;

  localparam int UNL  = 1000;
  localparam int LOC  = 5000;
  localparam int MAXF = 3;

  localparam int M_IDLE = 0, M_ENTRY = 1, M_UNL = 2, M_LOCK = 3, M_PROG = 4;

  logic            clk;
  logic            rst_n;
  logic            tb_prog;
  pin_lock_state_t dbg_state;

  pin_lock_ctrl_if bus ();

`ifdef PIN_LOCK_PROGRAM_EN
  assign bus.prog = tb_prog;
`endif

  pin_lock_ctrl #(
    .UNLOCK_CYCLES  (UNL),
    .LOCKOUT_CYCLES (LOC),
    .MAX_FAILS      (MAXF)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [7:0] exp_q[$];
  int         m_st;
  int         m_idx;
  bit         m_mm;
  int         m_fail;
  bit         m_err;
  int         m_err_cnt = 0;
  logic [3:0] m_pin [4];
  logic [3:0] m_sh  [4];

  function automatic bit pin_bad(input logic [3:0] d, input int k);
    return (d > 4'd9) || (d != m_pin[k]);
  endfunction

  task automatic model_reset();
    m_st = M_IDLE; m_idx = 0; m_mm = 0; m_fail = 0;
    m_pin = '{4'd9, 4'd9, 4'd7, 4'd9};
  endtask

  task automatic model_step(input bit e, input bit c, input bit p, input logic [3:0] d);
    m_err = 0;
    case (m_st)
      M_IDLE: if (e && !c) begin m_mm = pin_bad(d, 0); m_idx = 1; m_st = M_ENTRY; end
      M_ENTRY: begin
        if (c) begin m_idx = 0; m_mm = 0; m_st = M_IDLE; end
        else if (e) begin
          m_mm = m_mm | pin_bad(d, m_idx);
          if (m_idx < 3) m_idx++;
          else begin
            m_idx = 0;
            if (!m_mm) begin m_st = M_UNL; m_fail = 0; end
            else begin
              m_fail++; m_err = 1; m_err_cnt++;
              m_st = (m_fail == MAXF) ? M_LOCK : M_IDLE;
            end
            m_mm = 0;
          end
        end
      end
      M_UNL: if (c) m_st = M_IDLE; else if (p) begin m_st = M_PROG; m_idx = 0; end
      M_PROG: begin
        if (c) begin m_st = M_IDLE; m_idx = 0; end
        else if (e) begin
          m_sh[m_idx] = d;
          if (m_idx == 3) begin m_pin = m_sh; m_st = M_IDLE; m_idx = 0; end
          else m_idx++;
        end
      end
      default: ;
    endcase
    exp_q.push_back({2'(m_idx), (m_st == M_UNL || m_st == M_PROG), m_err,
                     (m_st == M_LOCK), 3'(m_fail)});
  endtask

  // ---------------- drivers ----------------
  task automatic strobe(input bit e, input bit c, input bit p, input logic [3:0] d);
    @(negedge clk);
    bus.enter = e; bus.cancel = c; tb_prog = p; bus.digit = d;
    model_step(e, c, p, d);
  endtask

  task automatic release_in();
    @(negedge clk);
    bus.enter = 1'b0; bus.cancel = 1'b0; tb_prog = 1'b0; bus.digit = 4'd0;
  endtask

  task automatic enter_pin(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d);
    strobe(1, 0, 0, a); strobe(1, 0, 0, b); strobe(1, 0, 0, c); strobe(1, 0, 0, d);
    release_in();
  endtask

  // ---------------- monitors ----------------
  int unl_run = 0, unl_len = 0, lo_run = 0, lo_len = 0, err_seen = 0;

  always @(posedge clk) begin
    bit due;
    due = bus.enter | bus.cancel | tb_prog;
    #1;
    if (due && rst_n) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else check("resp", {bus.digit_idx, bus.unlock, bus.error, bus.locked_out, bus.fail_cnt},
                 exp_q.pop_front());
    end
    if (bus.unlock) unl_run++;
    else if (unl_run != 0) begin unl_len = unl_run; unl_run = 0; end
    if (bus.locked_out) lo_run++;
    else if (lo_run != 0) begin lo_len = lo_run; lo_run = 0; end
    if (bus.error) err_seen++;
  end

  task automatic wait_unlock_end();
    int n = 0;
    unl_len = 0;
    while (bus.unlock && n < UNL + 20) begin @(negedge clk); n++; end
    check("unlock_expired", bus.unlock, 0);
    check("unlock_len", unl_len, UNL);
    m_st = M_IDLE;
  endtask

  task automatic wait_lockout_end();
    int n = 0;
    lo_len = 0;
    while (bus.locked_out && n < LOC + 20) begin @(negedge clk); n++; end
    check("lockout_expired", bus.locked_out, 0);
    check("lockout_len", lo_len, LOC);
    m_st = M_IDLE; m_fail = 0;
    check("fail_after_lockout", bus.fail_cnt, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bus.enter = 0; bus.cancel = 0; bus.digit = 0; tb_prog = 0;
    rst_n = 0;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_resp", {bus.digit_idx, bus.unlock, bus.error, bus.locked_out, bus.fail_cnt}, 0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    rst_n = 1;

    // correct PIN
    enter_pin(9, 9, 7, 9);
    wait_unlock_end();

    // wrong last digit
    enter_pin(9, 9, 7, 8);
    @(negedge clk);
    check("error_one_cycle", bus.error, 0);

    // cancel beats enter in the same cycle
    strobe(1, 0, 0, 9); strobe(1, 0, 0, 9); strobe(1, 1, 0, 7);
    release_in();
    enter_pin(9, 9, 7, 9);
    repeat (5) @(negedge clk);
    strobe(1, 0, 0, 3);          // ignored while unlocked
    strobe(0, 1, 0, 0);          // relock
    release_in();
    check("relock_state", 32'(dbg_state), 32'(ST_IDLE));

    // reset mid-entry with failure history
    enter_pin(1, 2, 3, 4);
    strobe(1, 0, 0, 9); strobe(1, 0, 0, 9);
    release_in();
    rst_n = 0;
    #1;
    check("midrst_resp", {bus.digit_idx, bus.unlock, bus.error, bus.locked_out, bus.fail_cnt}, 0);
    check("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    model_reset();
    @(negedge clk);
    rst_n = 1;
    enter_pin(9, 9, 7, 9);
    wait_unlock_end();

    // lockout after MAXF failures, incl. non-BCD digit and early-only mismatch
    enter_pin(9, 9, 7, 15);
    enter_pin(0, 9, 7, 9);
    enter_pin(9, 9, 7, 8);
    enter_pin(9, 9, 7, 9);       // ignored during lockout
    strobe(0, 1, 0, 0);
    release_in();
    wait_lockout_end();
    enter_pin(9, 9, 7, 9);
    wait_unlock_end();

`ifdef PIN_LOCK_PROGRAM_EN
    enter_pin(9, 9, 7, 9);
    strobe(0, 0, 1, 0);
    release_in();
    enter_pin(1, 2, 3, 4);
    enter_pin(9, 9, 7, 9);       // old PIN now fails
    enter_pin(1, 2, 3, 4);
    strobe(0, 0, 1, 0);
    strobe(1, 0, 0, 5); strobe(1, 0, 0, 6); strobe(0, 1, 0, 0);
    release_in();
    enter_pin(1, 2, 3, 4);       // PIN unchanged by aborted write
    wait_unlock_end();
    strobe(0, 0, 1, 0);          // prog outside UNLOCKED is ignored
    release_in();
    check("prog_ignored_state", 32'(dbg_state), 32'(ST_IDLE));
`endif

    repeat (3) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    check("error_pulses", err_seen, m_err_cnt);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
